// File: rtl/ysyx_23060025_axi_arbiter.sv
// ysyx_23060025_axi_arbiter: grants one shared AXI slave port to icache (m0) bursts or LSU (m1) accesses.
module ysyx_23060025_axi_arbiter #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_LEN-1:0]   m0_araddr,
    input  logic [7:0]            m0_arlen,
    input  logic [2:0]            m0_arsize,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_LEN-1:0]   m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rlast,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    input  logic [ADDR_LEN-1:0]   m1_araddr,
    input  logic [2:0]            m1_arsize,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_LEN-1:0]   m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    input  logic [ADDR_LEN-1:0]   m1_awaddr,
    input  logic [2:0]            m1_awsize,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [DATA_LEN-1:0]   m1_wdata,
    input  logic [DATA_LEN/8-1:0] m1_wstrb,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    output logic [1:0]            m1_bresp,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    output logic [ADDR_LEN-1:0]   s_araddr,
    output logic [7:0]            s_arlen,
    output logic [2:0]            s_arsize,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_LEN-1:0]   s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rlast,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic [ADDR_LEN-1:0]   s_awaddr,
    output logic [2:0]            s_awsize,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [DATA_LEN-1:0]   s_wdata,
    output logic [DATA_LEN/8-1:0] s_wstrb,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic [1:0]            s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready
);
    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_e;
    state_e state_q, state_d;
    logic pending_q, pending_d;
    logic if_g, rd_g, wr_g, r_done, b_done;
    assign if_g   = state_q == IF_RD;
    assign rd_g   = state_q == LS_RD;
    assign wr_g   = state_q == LS_WR;
    assign r_done = s_rvalid & s_rready & s_rlast;
    assign b_done = s_bvalid & s_bready;
    // pending_if lets a waiting icache fetch beat a back-to-back LSU read
    always_comb begin
        state_d = state_q == IDLE ?
                  (m1_awvalid ? LS_WR :
                   (m1_arvalid && !(m0_arvalid && pending_q)) ? LS_RD :
                   m0_arvalid ? IF_RD : IDLE) :
                  (((if_g || rd_g) && r_done) || (wr_g && b_done)) ? IDLE : state_q;
        pending_d = (state_q == IDLE && state_d == IF_RD) ? 1'b0 :
                    ((rd_g || wr_g) && state_d == IDLE && m0_arvalid) ? 1'b1 : pending_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end
    assign s_araddr   = if_g ? m0_araddr : rd_g ? m1_araddr : '0;
    assign s_arlen    = if_g ? m0_arlen : 8'd0;
    assign s_arsize   = if_g ? m0_arsize : rd_g ? m1_arsize : 3'd0;
    assign s_arvalid  = (if_g & m0_arvalid) | (rd_g & m1_arvalid);
    assign s_rready   = (if_g & m0_rready) | (rd_g & m1_rready);
    assign m0_arready = if_g & s_arready;
    assign m0_rdata   = if_g ? s_rdata : '0;
    assign m0_rresp   = if_g ? s_rresp : 2'd0;
    assign m0_rlast   = if_g & s_rlast;
    assign m0_rvalid  = if_g & s_rvalid;
    assign m1_arready = rd_g & s_arready;
    assign m1_rdata   = rd_g ? s_rdata : '0;
    assign m1_rresp   = rd_g ? s_rresp : 2'd0;
    assign m1_rvalid  = rd_g & s_rvalid;
    assign s_awaddr   = wr_g ? m1_awaddr : '0;
    assign s_awsize   = wr_g ? m1_awsize : 3'd0;
    assign s_awvalid  = wr_g & m1_awvalid;
    assign m1_awready = wr_g & s_awready;
    assign s_wdata    = wr_g ? m1_wdata : '0;
    assign s_wstrb    = wr_g ? m1_wstrb : '0;
    assign s_wvalid   = wr_g & m1_wvalid;
    assign m1_wready  = wr_g & s_wready;
    assign m1_bresp   = wr_g ? s_bresp : 2'd0;
    assign m1_bvalid  = wr_g & s_bvalid;
    assign s_bready   = wr_g & m1_bready;
endmodule

// File: tb/tb_ysyx_23060025_axi_arbiter.sv
// tb_ysyx_23060025_axi_arbiter: directed scenarios with a beat scoreboard for the AXI arbiter.
module tb_ysyx_23060025_axi_arbiter;
    logic clock, reset;
    logic [31:0] m0_araddr, m0_rdata, m1_araddr, m1_rdata, m1_awaddr, m1_wdata;
    logic [7:0] m0_arlen, s_arlen;
    logic [2:0] m0_arsize, m1_arsize, m1_awsize, s_arsize, s_awsize;
    logic m0_arvalid, m0_arready, m0_rlast, m0_rvalid, m0_rready;
    logic [1:0] m0_rresp, m1_rresp, m1_bresp, s_rresp, s_bresp;
    logic m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_awvalid, m1_awready;
    logic [3:0] m1_wstrb, s_wstrb;
    logic m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    int passed = 0, total = 0;
    logic [63:0] sb[$];

    ysyx_23060025_axi_arbiter #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
        .clock(clock), .reset(reset),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arsize(m1_arsize), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awsize(m1_awsize), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awsize(s_awsize), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // drives one slave R beat toward the granted master and scores it on the master side
    task automatic beat(input bit to_m0, input logic [31:0] d, input logic [1:0] r, input logic l);
        logic [63:0] e;
        s_rvalid = 1'b1; s_rdata = d; s_rresp = r; s_rlast = l;
        m0_rready = to_m0; m1_rready = !to_m0;
        sb.push_back({d, r, l});
        #1;
        e = sb.pop_front();
        if (to_m0) begin
            chk("m0_rvalid", m0_rvalid, 1);
            chk("m0_rbeat", {m0_rdata, m0_rresp, m0_rlast}, e);
            chk("m1_rvalid_off", m1_rvalid, 0);
        end else begin
            chk("m1_rvalid", m1_rvalid, 1);
            chk("m1_rbeat", {m1_rdata, m1_rresp}, e[34:1]);
            chk("m0_rvalid_off", m0_rvalid, 0);
        end
        chk("s_rready", s_rready, 1);
        cyc;
        s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
    endtask

    initial begin
        logic [63:0] e;
        {m0_araddr, m0_arlen, m0_arsize, m0_arvalid, m0_rready} = '0;
        {m1_araddr, m1_arsize, m1_arvalid, m1_rready} = '0;
        {m1_awaddr, m1_awsize, m1_awvalid, m1_wdata, m1_wstrb, m1_wvalid, m1_bready} = '0;
        {s_arready, s_rdata, s_rresp, s_rlast, s_rvalid} = '0;
        {s_awready, s_wready, s_bresp, s_bvalid} = '0;
        reset = 1'b1;
        s_arready = 1; s_awready = 1; s_wready = 1; m0_rready = 1; m1_rready = 1; m1_bready = 1;
        repeat (3) cyc;
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_awvalid", s_awvalid, 0);
        chk("rst_s_wvalid", s_wvalid, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_s_bready", s_bready, 0);
        chk("rst_m0_arready", m0_arready, 0);
        chk("rst_m1_arready", m1_arready, 0);
        chk("rst_m1_awready", m1_awready, 0);
        chk("rst_m1_wready", m1_wready, 0);
        s_arready = 0; s_awready = 0; s_wready = 0; m0_rready = 0; m1_rready = 0; m1_bready = 0;
        reset = 1'b0;
        cyc;
        // icache 4-beat burst
        m0_araddr = 32'h3000_0000; m0_arlen = 8'd3; m0_arsize = 3'd2; m0_arvalid = 1;
        #1;
        chk("t1_latency", s_arvalid, 0);
        cyc;
        s_arready = 1;
        #1;
        chk("t1_arvalid", s_arvalid, 1);
        chk("t1_araddr", s_araddr, 32'h3000_0000);
        chk("t1_arlen", s_arlen, 3);
        chk("t1_arsize", s_arsize, 2);
        chk("t1_m0_arready", m0_arready, 1);
        cyc;
        m0_arvalid = 0; s_arready = 0;
        for (int i = 0; i < 4; i++) beat(1, 32'ha000_0000 + i, 2'b00, i == 3);
        s_rvalid = 1; m0_rready = 1;
        #1;
        chk("t1_idle_rready", s_rready, 0);
        chk("t1_idle_stray", m0_rvalid, 0);
        s_rvalid = 0; m0_rready = 0;
        cyc;
        // simultaneous m0/m1 reads, LSU first then icache
        m0_araddr = 32'h3000_0040; m0_arlen = 8'd1; m0_arvalid = 1;
        m1_araddr = 32'h8000_0010; m1_arsize = 3'd2; m1_arvalid = 1;
        cyc;
        s_arready = 1;
        #1;
        chk("t2_ls_araddr", s_araddr, 32'h8000_0010);
        chk("t2_ls_arlen", s_arlen, 0);
        chk("t2_m1_arready", m1_arready, 1);
        chk("t2_m0_arready_off", m0_arready, 0);
        cyc;
        m1_arvalid = 0; s_arready = 0;
        beat(0, 32'h1111_2222, 2'b00, 1);
        m1_arvalid = 1;
        #1;
        chk("t2_idle_gap", s_arvalid, 0);
        cyc;
        s_arready = 1;
        #1;
        chk("t2_if_araddr", s_araddr, 32'h3000_0040);
        chk("t2_if_arlen", s_arlen, 1);
        chk("t2_m1_arready_off", m1_arready, 0);
        chk("t2_m0_arready", m0_arready, 1);
        cyc;
        m0_arvalid = 0; s_arready = 0;
        beat(1, 32'hc0de_0000, 2'b00, 0);
        beat(1, 32'hc0de_0001, 2'b00, 1);
        #1;
        chk("t2_idle_gap2", s_arvalid, 0);
        cyc;
        s_arready = 1;
        #1;
        chk("t2_ls2_araddr", s_araddr, 32'h8000_0010);
        cyc;
        m1_arvalid = 0; s_arready = 0;
        beat(0, 32'h5555_aaaa, 2'b10, 1);
        m1_rready = 1;
        #1;
        chk("t2_err_idle", s_rready, 0);
        m1_rready = 0;
        cyc;
        // write and read requested together, write first; W before AW
        m1_awaddr = 32'h0f00_0004; m1_awsize = 3'd2; m1_awvalid = 1;
        m1_araddr = 32'h8000_0020; m1_arvalid = 1;
        cyc;
        m1_wdata = 32'hdead_beef; m1_wstrb = 4'b1111; m1_wvalid = 1; s_wready = 1; s_arready = 1;
        #1;
        chk("t3_awvalid", s_awvalid, 1);
        chk("t3_awaddr", s_awaddr, 32'h0f00_0004);
        chk("t3_awsize", s_awsize, 2);
        chk("t3_wvalid", s_wvalid, 1);
        chk("t3_wdata", s_wdata, 32'hdead_beef);
        chk("t3_wstrb", s_wstrb, 4'b1111);
        chk("t3_wready", m1_wready, 1);
        chk("t3_awready_wait", m1_awready, 0);
        chk("t3_no_ar", s_arvalid, 0);
        chk("t3_no_arready", m1_arready, 0);
        cyc;
        m1_wvalid = 0; s_wready = 0; s_awready = 1;
        #1;
        chk("t3_awready", m1_awready, 1);
        chk("t3_w_done", s_wvalid, 0);
        cyc;
        m1_awvalid = 0; s_awready = 0;
        s_bvalid = 1; s_bresp = 2'b00; m1_bready = 1;
        sb.push_back(64'(2'b00));
        #1;
        chk("t3_bvalid", m1_bvalid, 1);
        e = sb.pop_front();
        chk("t3_bresp", m1_bresp, e);
        chk("t3_bready", s_bready, 1);
        cyc;
        s_bvalid = 0;
        #1;
        chk("t3_idle_ar", s_arvalid, 0);
        chk("t3_idle_bready", s_bready, 0);
        cyc;
        chk("t3_rd_arvalid", s_arvalid, 1);
        chk("t3_rd_araddr", s_araddr, 32'h8000_0020);
        chk("t3_rd_arready", m1_arready, 1);
        cyc;
        m1_arvalid = 0; s_arready = 0; m1_bready = 0;
        beat(0, 32'h0bad_f00d, 2'b00, 1);
        // reset in the middle of an icache burst
        m0_araddr = 32'h3000_1000; m0_arlen = 8'd3; m0_arvalid = 1;
        cyc;
        s_arready = 1;
        cyc;
        m0_arvalid = 0; s_arready = 0;
        beat(1, 32'h7700_0000, 2'b00, 0);
        s_rvalid = 1; s_rdata = 32'h7700_0001; m0_rready = 1; reset = 1;
        cyc;
        chk("t4_rst_rvalid", m0_rvalid, 0);
        chk("t4_rst_rready", s_rready, 0);
        reset = 0; s_rvalid = 0; m0_rready = 0;
        m1_araddr = 32'h8000_0030; m1_arvalid = 1;
        #1;
        chk("t4_latency", s_arvalid, 0);
        cyc;
        chk("t4_regrant", s_arvalid, 1);
        chk("t4_araddr", s_araddr, 32'h8000_0030);
        s_arready = 1;
        cyc;
        m1_arvalid = 0; s_arready = 0;
        beat(0, 32'h1234_5678, 2'b00, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
